// File: rtl/mux2_rr_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mux2_rr_arbiter : round-robin, burst-limited arbiter for a 2:1 mux with a
//                   registered valid/ready output stage.
// Revision: 1.0
// ----------------------------------------------------------------------------
module mux2_rr_arbiter #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [DATA_W-1:0] din0,
  input  logic [DATA_W-1:0] din1,
  input  logic              out_ready,
  output logic [1:0]        grant,
  output logic              sel,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  localparam int              CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t              state_q;
  logic                last_q;
  logic                sel_q;
  logic                out_valid_q;
  logic [DATA_W-1:0]   out_data_q;
  logic [CNT_W-1:0]    cnt_q;

  logic                port;
  logic                own_req;
  logic                oth_req;
  logic                load;
  logic                accept;
  logic                at_limit;
  logic [DATA_W-1:0]   din_sel;

  assign grant     = {state_q == GNT1, state_q == GNT0};
  assign port      = (state_q == GNT1);
  assign own_req   = port ? req[1] : req[0];
  assign oth_req   = port ? req[0] : req[1];
  assign load      = ~out_valid_q | out_ready;
  assign accept    = (|grant) & own_req & load;
  assign at_limit  = (cnt_q == LIMIT);
  assign din_sel   = port ? din1 : din0;

  assign sel       = sel_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      sel_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      cnt_q       <= '0;
    end else begin
      if (accept) begin
        out_data_q <= din_sel;
        last_q     <= port;
      end

      if (accept) begin
        out_valid_q <= 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          // On a tie the port that did not win last time goes first.
          if (req == 2'b11) begin
            state_q <= last_q ? GNT0 : GNT1;
            sel_q   <= ~last_q;
          end else if (req[0]) begin
            state_q <= GNT0;
            sel_q   <= 1'b0;
          end else if (req[1]) begin
            state_q <= GNT1;
            sel_q   <= 1'b1;
          end
        end
        default: begin
          if (!own_req) begin
            cnt_q <= '0;
            if (oth_req) begin
              state_q <= port ? GNT0 : GNT1;
              sel_q   <= ~port;
            end else begin
              state_q <= IDLE;
            end
          end else if (accept) begin
            if (at_limit) begin
              cnt_q <= '0;
              if (oth_req) begin
                state_q <= port ? GNT0 : GNT1;
                sel_q   <= ~port;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mux2_rr_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mux2_rr_arbiter : two instances (MAX_BURST=4 and 1) driven by common
//                      stimulus and compared against a behavioural model.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_mux2_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [7:0] din0, din1;
  logic       out_ready;

  logic [1:0] gnt_a, gnt_b;
  logic       sel_a, sel_b, vld_a, vld_b;
  logic [7:0] dat_a, dat_b;

  int n_err = 0;
  int n_chk = 0;

  // Behavioural model state, one slot per instance (0: burst 4, 1: burst 1).
  int         owner[2];
  int         beats[2];
  int         lastp[2];
  int         maxb[2];
  logic       expv[2];
  logic [7:0] expd[2];
  logic       exps[2];

  always #5 clk = ~clk;

  mux2_rr_arbiter #(.DATA_W(8), .MAX_BURST(4)) dut_a (
    .clk(clk), .rst(rst), .req(req), .din0(din0), .din1(din1),
    .out_ready(out_ready), .grant(gnt_a), .sel(sel_a),
    .out_valid(vld_a), .out_data(dat_a)
  );

  mux2_rr_arbiter #(.DATA_W(8), .MAX_BURST(1)) dut_b (
    .clk(clk), .rst(rst), .req(req), .din0(din0), .din1(din1),
    .out_ready(out_ready), .grant(gnt_b), .sel(sel_b),
    .out_valid(vld_b), .out_data(dat_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    maxb[0] = 4;
    maxb[1] = 1;
    for (int k = 0; k < 2; k++) begin
      owner[k] = -1;
      beats[k] = 0;
      lastp[k] = 1;
      expv[k]  = 1'b0;
      expd[k]  = 8'h00;
      exps[k]  = 1'b0;
    end
  endtask

  function automatic logic [1:0] exp_grant(input int k);
    if (owner[k] < 0) return 2'b00;
    return (owner[k] == 0) ? 2'b01 : 2'b10;
  endfunction

  // Advances the model by one clock edge using the currently driven inputs.
  task automatic model_update(input int k);
    int  g;
    bit  acc;
    g   = owner[k];
    acc = (g >= 0) && req[g] && (!expv[k] || out_ready);
    if (acc) begin
      expd[k]  = (g == 1) ? din1 : din0;
      expv[k]  = 1'b1;
      lastp[k] = g;
    end else if (out_ready) begin
      expv[k] = 1'b0;
    end
    if (g < 0) begin
      if (req == 2'b11)  owner[k] = 1 - lastp[k];
      else if (req[0])   owner[k] = 0;
      else if (req[1])   owner[k] = 1;
    end else if (!req[g]) begin
      beats[k] = 0;
      owner[k] = req[1-g] ? 1 - g : -1;
    end else if (acc) begin
      beats[k]++;
      if (beats[k] == maxb[k]) begin
        beats[k] = 0;
        if (req[1-g]) owner[k] = 1 - g;
      end
    end
    if (owner[k] >= 0) exps[k] = owner[k][0];
  endtask

  task automatic check_all();
    chk("grant_b4", {30'd0, gnt_a}, {30'd0, exp_grant(0)});
    chk("sel_b4",   {31'd0, sel_a}, {31'd0, exps[0]});
    chk("valid_b4", {31'd0, vld_a}, {31'd0, expv[0]});
    chk("data_b4",  {24'd0, dat_a}, {24'd0, expd[0]});
    chk("grant_b1", {30'd0, gnt_b}, {30'd0, exp_grant(1)});
    chk("sel_b1",   {31'd0, sel_b}, {31'd0, exps[1]});
    chk("valid_b1", {31'd0, vld_b}, {31'd0, expv[1]});
    chk("data_b1",  {24'd0, dat_b}, {24'd0, expd[1]});
  endtask

  task automatic step(input logic [1:0] r, input logic rdy, input logic [7:0] d0, input logic [7:0] d1);
    @(negedge clk);
    check_all();
    req       = r;
    out_ready = rdy;
    din0      = d0;
    din1      = d1;
    model_update(0);
    model_update(1);
  endtask

  initial begin
    rst       = 1'b1;
    req       = 2'b00;
    din0      = 8'h00;
    din1      = 8'h00;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Release into contention: port 0 must win the first tie.
    step(2'b11, 1'b1, 8'hA0, 8'hB0);
    step(2'b00, 1'b1, 8'hA1, 8'hB1);
    step(2'b00, 1'b1, 8'h00, 8'h00);

    // Single source with an incrementing word stream.
    for (int i = 0; i < 10; i++) step(2'b01, 1'b1, 8'h0F + 8'(i), 8'h55);
    step(2'b00, 1'b1, 8'h00, 8'h00);

    // Full contention, consumer always ready.
    for (int i = 0; i < 24; i++) step(2'b11, 1'b1, 8'(8'h40 + i), 8'(8'hC0 + i));

    // Backpressure while port 0 is granted.
    for (int i = 0; i < 3; i++) step(2'b01, 1'b1, 8'(8'h20 + i), 8'h00);
    for (int i = 0; i < 3; i++) step(2'b01, 1'b0, 8'h23, 8'h00);
    for (int i = 0; i < 3; i++) step(2'b01, 1'b1, 8'(8'h24 + i), 8'h00);

    // Handover and drop to idle.
    for (int i = 0; i < 3; i++) step(2'b10, 1'b1, 8'h00, 8'(8'h60 + i));
    for (int i = 0; i < 2; i++) step(2'b01, 1'b1, 8'(8'h70 + i), 8'h00);
    for (int i = 0; i < 2; i++) step(2'b10, 1'b1, 8'h00, 8'(8'h80 + i));
    step(2'b00, 1'b0, 8'h00, 8'h00);
    step(2'b00, 1'b0, 8'h00, 8'h00);
    step(2'b00, 1'b1, 8'h00, 8'h00);
    step(2'b00, 1'b1, 8'h00, 8'h00);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step(2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
           8'($urandom), 8'($urandom));

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 3; i++) step(2'b11, 1'b1, 8'(8'h90 + i), 8'(8'hE0 + i));
    @(negedge clk);
    check_all();
    chk("pre_rst_valid", {31'd0, vld_a}, 32'd1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("rst_grant", {28'd0, gnt_a, gnt_b}, 32'd0);
    chk("rst_valid", {30'd0, vld_a, vld_b}, 32'd0);
    chk("rst_data",  {16'd0, dat_a, dat_b}, 32'd0);
    chk("rst_sel",   {30'd0, sel_a, sel_b}, 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    req       = 2'b11;
    out_ready = 1'b1;
    din0      = 8'h33;
    din1      = 8'h44;
    model_update(0);
    model_update(1);
    @(negedge clk);
    chk("post_rst_grant", {30'd0, gnt_a}, 32'd1);
    check_all();
    req = 2'b11;
    model_update(0);
    model_update(1);
    for (int i = 0; i < 10; i++) step(2'b11, 1'b1, 8'(8'hD0 + i), 8'(8'h10 + i));
    step(2'b00, 1'b1, 8'h00, 8'h00);
    @(negedge clk);
    check_all();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
